// File: rtl/msa_message_scheduler_pkg.sv
// Shared definitions for the SHA-256 message scheduler.
// Provides the schedule/chunk sizes, the FSM state encodings, the 32-bit
// rotate helper and the two message-schedule sigma functions.
package msa_message_scheduler_pkg;

  localparam int unsigned SCHEDULE_WORDS = 64;
  localparam int unsigned CHUNK_WORDS    = 16;
  localparam int unsigned EXPAND_WORDS   = SCHEDULE_WORDS - CHUNK_WORDS;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;

  function automatic logic [31:0] right_rotate32(input logic [31:0] x,
                                                 input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0_small(input logic [31:0] x);
    return right_rotate32(x, 7) ^ right_rotate32(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1_small(input logic [31:0] x);
    return right_rotate32(x, 17) ^ right_rotate32(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/msa_message_scheduler_schedule_word.sv
// One SHA-256 message-schedule word:
//   w_out = sigma1(w_m2) + w_m7 + sigma0(w_m15) + w_m16   (mod 2^32)
// Ports:
//   w_m2, w_m7, w_m15, w_m16 : W[t-2], W[t-7], W[t-15], W[t-16]
//   w_out                    : W[t]
// Purely combinational.
module msa_schedule_word
  import msa_message_scheduler_pkg::*;
(
  input  logic [31:0] w_m2,
  input  logic [31:0] w_m7,
  input  logic [31:0] w_m15,
  input  logic [31:0] w_m16,
  output logic [31:0] w_out
);

  always_comb begin
    w_out = sigma1_small(w_m2) + w_m7 + sigma0_small(w_m15) + w_m16;
  end

endmodule

// File: rtl/msa_message_scheduler.sv
// SHA-256 message scheduler: accepts one 16-word chunk, expands it to the
// 64-word schedule WORDS_PER_CYCLE words per clock, then holds it on a
// valid/ready port until the compressor takes it.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   chunk_vld/chunk_rdy : chunk handshake, chunk[i] = W[i]
//   w_vld/w_rdy         : schedule handshake, w[i] = W[i]
//   busy                : high while expanding or presenting a schedule
module msa_message_scheduler
  import msa_message_scheduler_pkg::*;
#(
  parameter int unsigned WORDS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               chunk_rdy,
  input  logic               chunk_vld,
  input  logic [15:0][31:0]  chunk,
  input  logic               w_rdy,
  output logic               w_vld,
  output logic [63:0][31:0]  w,
  output logic               busy
);

  if (WORDS_PER_CYCLE == 0 || (EXPAND_WORDS % WORDS_PER_CYCLE) != 0) begin : g_bad_wpc
    $error("WORDS_PER_CYCLE must divide 48");
  end

  logic [1:0]                          state;
  logic [6:0]                          idx;
  logic [6:0]                          idx_next;
  logic [SCHEDULE_WORDS-1:0][31:0]     sched;
  logic [WORDS_PER_CYCLE-1:0][31:0]    fresh;

  // The schedule is kept as a shift register: a chunk is loaded into the top
  // 16 slots and every EXPAND cycle shifts the array down by WORDS_PER_CYCLE,
  // appending the new words at the top. After 48 words have been shifted in,
  // slot p holds W[p]. This keeps the recurrence taps at fixed positions:
  // W[idx+k-j] is sched[64+k-j] when k<j, otherwise this cycle's fresh[k-j].
  for (genvar k = 0; k < WORDS_PER_CYCLE; k++) begin : g_word
    logic [31:0] m2, m7, m15, m16;

    if (k >= 2) begin : g_m2_chain
      assign m2 = fresh[k-2];
    end else begin : g_m2_reg
      assign m2 = sched[SCHEDULE_WORDS+k-2];
    end

    if (k >= 7) begin : g_m7_chain
      assign m7 = fresh[k-7];
    end else begin : g_m7_reg
      assign m7 = sched[SCHEDULE_WORDS+k-7];
    end

    if (k >= 15) begin : g_m15_chain
      assign m15 = fresh[k-15];
    end else begin : g_m15_reg
      assign m15 = sched[SCHEDULE_WORDS+k-15];
    end

    if (k >= 16) begin : g_m16_chain
      assign m16 = fresh[k-16];
    end else begin : g_m16_reg
      assign m16 = sched[SCHEDULE_WORDS+k-16];
    end

    msa_schedule_word u_word (
      .w_m2  (m2),
      .w_m7  (m7),
      .w_m15 (m15),
      .w_m16 (m16),
      .w_out (fresh[k])
    );
  end

  assign idx_next = idx + 7'(WORDS_PER_CYCLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= 7'(CHUNK_WORDS);
    end else begin
      case (state)
        ST_IDLE: begin
          if (chunk_vld) begin
            sched[SCHEDULE_WORDS-1:EXPAND_WORDS] <= chunk;
            idx   <= 7'(CHUNK_WORDS);
            state <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          for (int unsigned i = 0; i < SCHEDULE_WORDS - WORDS_PER_CYCLE; i++) begin
            sched[i] <= sched[i+WORDS_PER_CYCLE];
          end
          for (int unsigned k = 0; k < WORDS_PER_CYCLE; k++) begin
            sched[SCHEDULE_WORDS-WORDS_PER_CYCLE+k] <= fresh[k];
          end
          idx <= idx_next;
          if (idx_next == 7'(SCHEDULE_WORDS)) begin
            state <= ST_OUTPUT;
          end
        end
        ST_OUTPUT: begin
          if (w_rdy) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (idx <= 7'(SCHEDULE_WORDS))
        else $error("schedule index exceeded 64");
    end
  end

  assign chunk_rdy = (state == ST_IDLE) & ~rst;
  assign w_vld     = (state == ST_OUTPUT);
  assign busy      = (state != ST_IDLE);
  assign w         = sched;

endmodule

// File: tb/tb_msa_message_scheduler.sv
`timescale 1ns/1ps
module tb_msa_message_scheduler;

  localparam int LAT1 = 48;

  logic               clk = 1'b0;
  logic               rst;
  logic               chunk_rdy, chunk_vld;
  logic [15:0][31:0]  chunk;
  logic               w_rdy, w_vld, busy;
  logic [63:0][31:0]  w;

  logic               chunk4_rdy, chunk4_vld, w4_vld, busy4;
  logic [63:0][31:0]  w4;
  logic               w4_rdy = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = 0;
  int n_acc = 0;
  int n_out = 0;
  logic prev_vld = 1'b0;

  logic [63:0][31:0] sb[$];
  int                acc_cyc[$];

  msa_message_scheduler #(.WORDS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst(rst), .chunk_rdy(chunk_rdy), .chunk_vld(chunk_vld),
    .chunk(chunk), .w_rdy(w_rdy), .w_vld(w_vld), .w(w), .busy(busy));

  msa_message_scheduler #(.WORDS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .chunk_rdy(chunk4_rdy), .chunk_vld(chunk4_vld),
    .chunk(chunk), .w_rdy(w4_rdy), .w_vld(w4_vld), .w(w4), .busy(busy4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [63:0][31:0] ref_schedule(input logic [15:0][31:0] c);
    logic [63:0][31:0] r;
    logic [31:0] a, b, s0, s1;
    for (int i = 0; i < 16; i++) r[i] = c[i];
    for (int i = 16; i < 64; i++) begin
      a  = r[i-15];
      b  = r[i-2];
      s0 = ror(a, 7) ^ ror(a, 18) ^ (a >> 3);
      s1 = ror(b, 17) ^ ror(b, 19) ^ (b >> 10);
      r[i] = s1 + r[i-7] + s0 + r[i-16];
    end
    return r;
  endfunction

  function automatic int first_diff(input logic [63:0][31:0] a, input logic [63:0][31:0] b);
    for (int i = 0; i < 64; i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [63:0][31:0] got,
                         input logic [63:0][31:0] exp);
    int d;
    checks++;
    d = first_diff(got, exp);
    if (d >= 0) begin
      errors++;
      $display("FAIL %s: word %0d got=%h expected=%h", name, d, got[d], exp[d]);
    end
  endtask

  // Scoreboard: push the reference schedule on every accept, pop on every
  // output handshake. Sampled at negedge, so the values seen are those the
  // next rising edge will act on.
  always @(negedge clk) begin
    logic [63:0][31:0] exp;
    if (!rst) begin
      if (chunk_vld && chunk_rdy) begin
        sb.push_back(ref_schedule(chunk));
        acc_cyc.push_back(cyc);
        last_acc = cyc;
        n_acc++;
      end
      if (w_vld && !prev_vld) begin
        // cyc has already counted the accepting edge, hence +1.
        chk("latency", 32'(cyc - last_acc), 32'(LAT1 + 1));
      end
      if (w_vld && w_rdy) begin
        n_out++;
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
          exp = sb.pop_front();
          chk_vec("schedule", w, exp);
        end
      end
    end
    prev_vld = w_vld;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0][31:0] c);
    bit done;
    done = 1'b0;
    chunk = c;
    chunk_vld = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      done = chunk_rdy;
      tick();
    end
    chunk_vld = 1'b0;
    chk("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_vld(input int max);
    for (int i = 0; i < max && !w_vld; i++) tick();
    chk("vld_timeout", 32'(w_vld), 32'd1);
  endtask

  typedef struct {
    logic [15:0][31:0] chunk;
    int                rdy_gap;
    logic [31:0]       w16;
    logic [31:0]       w17;
    logic [31:0]       w63;
  } vec_t;

  vec_t vt[5];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0][31:0] abc, ones, c;
    logic [63:0][31:0] r, snap;
    bit hs;
    int sent;

    abc = '0;
    abc[0] = 32'h61626380;
    abc[15] = 32'h00000018;
    ones = '1;

    vt[0].chunk = abc; vt[0].rdy_gap = 0;
    vt[0].w16 = 32'h61626380; vt[0].w17 = 32'h000F0000; vt[0].w63 = 32'h12B1EDEB;
    vt[1].chunk = ones; vt[1].rdy_gap = 3;
    vt[2].chunk = '0;   vt[2].rdy_gap = 1;
    for (int i = 0; i < 16; i++) c[i] = 32'(i) * 32'h01010101 + 32'h10203040;
    vt[3].chunk = c;    vt[3].rdy_gap = 5;
    for (int i = 0; i < 16; i++) c[i] = 32'h1 << (2 * i);
    vt[4].chunk = c;    vt[4].rdy_gap = 0;
    for (int v = 1; v < 5; v++) begin
      r = ref_schedule(vt[v].chunk);
      vt[v].w16 = r[16]; vt[v].w17 = r[17]; vt[v].w63 = r[63];
    end

    rst = 1'b1; chunk_vld = 1'b0; chunk4_vld = 1'b0; w_rdy = 1'b0; chunk = '0;
    repeat (3) tick();
    chk("rst_chunk_rdy", 32'(chunk_rdy), 32'd0);
    chk("rst_w_vld", 32'(w_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_chunk_rdy", 32'(chunk_rdy), 32'd1);

    // Table-driven vectors
    for (int v = 0; v < 5; v++) begin
      w_rdy = (vt[v].rdy_gap == 0);
      send(vt[v].chunk);
      chk("busy_expand", 32'(busy), 32'd1);
      wait_vld(60);
      chk("w16", w[16], vt[v].w16);
      chk("w17", w[17], vt[v].w17);
      chk("w63", w[63], vt[v].w63);
      if (vt[v].rdy_gap > 0) begin
        repeat (vt[v].rdy_gap) tick();
        chk("vld_hold", 32'(w_vld), 32'd1);
        w_rdy = 1'b1;
      end
      tick();
      chk("idle_after_hs", 32'(chunk_rdy), 32'd1);
      chk("vld_drop", 32'(w_vld), 32'd0);
    end

    // WORDS_PER_CYCLE=4 against the reference, 12-cycle latency
    w_rdy = 1'b1;
    chunk = abc; chunk_vld = 1'b1; chunk4_vld = 1'b1;
    tick();
    chunk_vld = 1'b0; chunk4_vld = 1'b0;
    repeat (11) tick();
    chk("wpc4_not_early", 32'(w4_vld), 32'd0);
    tick();
    chk("wpc4_vld", 32'(w4_vld), 32'd1);
    chk_vec("wpc4_schedule", w4, ref_schedule(abc));
    wait_vld(60);
    tick();

    // Backpressure with a pending chunk
    w_rdy = 1'b0;
    send(abc);
    wait_vld(60);
    snap = w;
    chunk = ones; chunk_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_vld", 32'(w_vld), 32'd1);
      chk("bp_chunk_rdy", 32'(chunk_rdy), 32'd0);
      chk_vec("bp_stable", w, snap);
    end
    w_rdy = 1'b1;
    tick();
    chk("bp_idle", 32'(chunk_rdy), 32'd1);
    chk("bp_busy_idle", 32'(busy), 32'd0);
    tick();
    chk("bp_pending_accepted", 32'(busy), 32'd1);
    chunk_vld = 1'b0;
    wait_vld(60);
    tick();

    // Back-to-back: second chunk accepted 50 cycles after the first
    acc_cyc.delete();
    chunk = abc; chunk_vld = 1'b1;
    for (int i = 0; i < 200 && acc_cyc.size() < 2; i++) begin
      tick();
      if (acc_cyc.size() == 1) chunk = ones;
    end
    chunk_vld = 1'b0;
    if (acc_cyc.size() == 2) chk("b2b_interval", 32'(acc_cyc[1] - acc_cyc[0]), 32'd50);
    else chk("b2b_accepts", 32'(acc_cyc.size()), 32'd2);
    wait_vld(60);
    tick();

    // Reset at idx=30 during EXPAND
    send(abc);
    repeat (14) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_vld", 32'(w_vld), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_chunk_rdy", 32'(chunk_rdy), 32'd0);
    sb.delete();
    n_acc--;
    rst = 1'b0;
    #1;
    chk("after_rst_chunk_rdy", 32'(chunk_rdy), 32'd1);
    chk("after_rst_vld", 32'(w_vld), 32'd0);
    send(abc);
    wait_vld(60);
    tick();

    // Random chunks, random gaps and backpressure
    sent = 0;
    for (int i = 0; i < 40000 && (sent < 400 || sb.size() != 0); i++) begin
      w_rdy = ($urandom_range(0, 3) != 0);
      if (!chunk_vld && sent < 400 && $urandom_range(0, 3) == 0) begin
        for (int j = 0; j < 16; j++) chunk[j] = $urandom();
        chunk_vld = 1'b1;
      end
      hs = chunk_vld && chunk_rdy;
      tick();
      if (hs) begin
        chunk_vld = 1'b0;
        sent++;
      end
    end
    w_rdy = 1'b0;
    chk("rand_sent", 32'(sent), 32'd400);
    chk("rand_sb_empty", 32'(sb.size()), 32'd0);
    chk("acc_vs_out", 32'(n_out), 32'(n_acc));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
